// File: rtl/lc4_seq_divider.sv
// Iterative 16-bit unsigned restoring divider for the LC4 DIV/MOD datapath.
// Each RUN cycle performs one restoring step through a shared cla16 subtractor.

module cla16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum
);
    logic [14:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [2:0]  w_gg;
    logic [2:0]  w_gp;
    logic [3:0]  w_gc;

    // Carries into positions 0..3 of a 4-wide block, in flat lookahead form.
    function automatic logic [3:0] f_look(input logic [2:0] g, input logic [2:0] p, input logic c0);
        f_look[0] = c0;
        f_look[1] = g[0] | (p[0] & c0);
        f_look[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        f_look[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    endfunction

    assign w_g = i_a[14:0] & i_b[14:0];
    assign w_p = i_a ^ i_b;

    for (genvar j = 0; j < 3; j++) begin : g_grp
        assign w_gp[j] = &w_p[4*j +: 4];
        assign w_gg[j] = w_g[4*j+3]
                       | (w_p[4*j+3] & w_g[4*j+2])
                       | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                       | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
    end

    for (genvar j = 0; j < 4; j++) begin : g_bit
        assign w_c[4*j +: 4] = f_look(w_g[4*j +: 3], w_p[4*j +: 3], w_gc[j]);
    end

    assign w_gc  = f_look(w_gg, w_gp, i_cin);
    assign o_sum = w_p ^ w_c;
endmodule

module lc4_seq_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_rem;
    logic [15:0] r_quo;
    logic [15:0] r_dvs;
    logic [4:0]  r_count;
    logic        r_dbz;

    logic [15:0] w_shifted;
    logic [15:0] w_b;
    logic [15:0] w_diff;
    logic        w_cout;
    logic        w_ge;

    assign w_shifted = {r_rem[14:0], r_quo[15]};
    assign w_b       = ~r_dvs;

    cla16 u_cla16 (
        .i_a   (w_shifted),
        .i_b   (w_b),
        .i_cin (1'b1),
        .o_sum (w_diff)
    );

    // Bit-15 carry recovered from the sum: when p15=1 the incoming carry is ~sum15.
    assign w_cout = (w_shifted[15] & w_b[15]) | ((w_shifted[15] ^ w_b[15]) & ~w_diff[15]);
    assign w_ge   = r_rem[15] | w_cout;

    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done_valid  = (r_state == S_DONE);
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

    // NOTE: every state register is async-cleared so a mid-operation reset leaves no stale result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_count <= '0;
            r_dbz   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every step reads the pre-edge rem/quo pair.
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_dvs   <= divisor;
                        r_rem   <= '0;
                        r_count <= '0;
                        if (divisor == 16'd0) begin
                            r_quo   <= '0;
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_quo   <= dividend;
                            r_dbz   <= 1'b0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_ge ? w_diff : w_shifted;
                    r_quo   <= {r_quo[14:0], w_ge};
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd15) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (done_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc4_seq_divider.sv
// Directed self-checking bench for lc4_seq_divider with hand-computed results.

module tb_lc4_seq_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_mis = 0;

    lc4_seq_divider u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a request at a falling edge; returns at the falling edge after the accepting edge.
    task automatic start_div(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend    = a;
        divisor     = b;
        start_valid = 1'b1;
        check("start_ready_before_accept", start_ready, 1);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    // Counts falling edges after the accepting edge until done_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("done_within_budget", done_valid, 1);
    endtask

    task automatic release_done();
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("done_dropped", done_valid, 0);
        check("idle_after_release", start_ready, 1);
    endtask

    task automatic expect_result(input string tag, input logic [15:0] q, input logic [15:0] r, input logic z);
        check({tag, "_quotient"},  quotient,    q);
        check({tag, "_remainder"}, remainder,   r);
        check({tag, "_dbz"},       div_by_zero, z);
    endtask

    initial begin
        int lat;
        logic seen_done;

        #12;
        check("reset_start_ready", start_ready, 1);
        check("reset_busy",        busy,        0);
        check("reset_done_valid",  done_valid,  0);
        check("reset_quotient",    quotient,    0);
        check("reset_remainder",   remainder,   0);
        check("reset_dbz",         div_by_zero, 0);
        rst_n = 1'b1;

        start_div(16'd100, 16'd7);
        check("busy_in_run", busy, 1);
        wait_done(lat);
        check("latency_100_7", lat, 17);
        expect_result("d100_7", 16'd14, 16'd2, 1'b0);
        release_done();

        start_div(16'hFFFF, 16'h8001);
        wait_done(lat);
        expect_result("dffff_8001", 16'h0001, 16'h7FFE, 1'b0);
        release_done();

        start_div(16'hFFFF, 16'h0001);
        wait_done(lat);
        expect_result("dffff_0001", 16'hFFFF, 16'h0000, 1'b0);
        release_done();

        start_div(16'h1234, 16'h0000);
        wait_done(lat);
        check("latency_div0", lat, 1);
        expect_result("d1234_0", 16'h0000, 16'h0000, 1'b1);
        release_done();

        start_div(16'h0005, 16'h0009);
        wait_done(lat);
        expect_result("d5_9", 16'h0000, 16'h0005, 1'b0);
        dividend    = 16'd77;
        divisor     = 16'd3;
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_done_valid",  done_valid,  1);
            check("hold_start_ready", start_ready, 0);
            check("hold_quotient",    quotient,    16'h0000);
            check("hold_remainder",   remainder,   16'h0005);
        end
        start_valid = 1'b0;
        release_done();
        check("hold_result_kept_q", quotient,  16'h0000);
        check("hold_result_kept_r", remainder, 16'h0005);

        // Back-to-back with start_valid held high across the first done handshake.
        @(negedge clk);
        dividend    = 16'd50;
        divisor     = 16'd5;
        start_valid = 1'b1;
        @(negedge clk);
        dividend    = 16'd49;
        wait_done(lat);
        check("b2b_first_latency", lat, 17);
        expect_result("d50_5", 16'd10, 16'd0, 1'b0);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("b2b_no_accept_at_handshake", start_ready, 1);
        check("b2b_done_dropped", done_valid, 0);
        @(negedge clk);
        start_valid = 1'b0;
        check("b2b_second_accepted", busy, 1);
        wait_done(lat);
        check("b2b_second_latency", lat, 17);
        expect_result("d49_5", 16'd9, 16'd4, 1'b0);
        release_done();

        // Reset in the middle of RUN.
        start_div(16'd1000, 16'd7);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",        busy,        0);
        check("midrst_start_ready", start_ready, 1);
        expect_result("midrst", 16'd0, 16'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done_valid) seen_done = 1'b1;
        end
        check("midrst_no_done_pulse", seen_done, 0);
        check("midrst_idle", start_ready, 1);

        start_div(16'd9, 16'd3);
        wait_done(lat);
        expect_result("d9_3", 16'd3, 16'd0, 1'b0);
        release_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
